// File: rtl/ad9911_pkg.sv
// AD9911 register map, frame sizing and writer state encoding.
// Shared by the SPI writer and anything that builds register writes.
package ad9911_pkg;

  localparam logic [7:0] ADDR_CSR   = 8'h00;
  localparam logic [7:0] ADDR_FR1   = 8'h01;
  localparam logic [7:0] ADDR_FR2   = 8'h02;
  localparam logic [7:0] ADDR_CFR   = 8'h03;
  localparam logic [7:0] ADDR_CTW0  = 8'h04;
  localparam logic [7:0] ADDR_CPOW0 = 8'h05;
  localparam logic [7:0] ADDR_ACR   = 8'h06;
  localparam logic [7:0] ADDR_LSRR  = 8'h07;
  localparam logic [7:0] ADDR_RDW   = 8'h08;
  localparam logic [7:0] ADDR_FDW   = 8'h09;
  localparam logic [7:0] ADDR_CTW1  = 8'h0A;
  localparam logic [7:0] ADDR_MAX   = 8'h18;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_CSHOLD,
    S_IOUPD,
    S_REJECT
  } state_t;

  function automatic logic [2:0] byte_count(
    input logic [7:0] a
  );
    case (a)
      ADDR_CSR:                     return 3'd1;
      ADDR_FR2, ADDR_CPOW0,
      ADDR_LSRR:                    return 3'd2;
      ADDR_FR1, ADDR_CFR,
      ADDR_ACR:                     return 3'd3;
      default:                      return 3'd4;
    endcase
  endfunction

  function automatic logic [5:0] frame_bits(
    input logic [7:0] a
  );
    return {byte_count(a) + 3'd1, 3'b000};
  endfunction

  // Instruction byte plus payload, left-aligned so bit 39 goes out first.
  function automatic logic [39:0] frame_word(
    input logic [7:0]  a,
    input logic [31:0] d
  );
    logic [31:0] p;
    case (byte_count(a))
      3'd1:    p = {d[7:0], 24'h0};
      3'd2:    p = {d[15:0], 16'h0};
      3'd3:    p = {d[23:0], 8'h0};
      default: p = d;
    endcase
    return {3'b000, a[4:0], p};
  endfunction

endpackage

// File: rtl/ad9911_spi_writer.sv
// Serial register writer for the AD9911 DDS: instruction + payload
// shifted MSB first, followed by an IO_UPDATE strobe.
module ad9911_spi_writer
  import ad9911_pkg::*;
#(
  parameter int IOUPD_CYCLES = 4
) (
  input  logic        CLOCK_10M,
  input  logic        RESET_N,
  input  logic        TR,
  input  logic [7:0]  ADDR,
  input  logic [31:0] DATA,
  input  logic        MRSET,
  output logic        BUSY,
  output logic        SCLK,
  output logic        SDIO,
  output logic        CS_N,
  output logic        IO_UPDATE,
  output logic        MASTER_RESET
);

  localparam logic [3:0] LP_IOU_LAST = 4'(IOUPD_CYCLES - 1);

  state_t      r_state;
  state_t      w_nxt;
  logic        r_tr;
  logic [39:0] r_sh;
  logic        r_ph;
  logic [5:0]  r_bits;
  logic [3:0]  r_cnt;
  logic        r_busy;
  logic        r_csn;
  logic        r_ioupd;
  logic        r_mrst;
  logic        w_acc;
  logic        w_valid;

  assign w_acc   = TR & ~r_tr & ~MRSET & (r_state == S_IDLE);
  assign w_valid = (ADDR <= ADDR_MAX);

  always_ff @(posedge CLOCK_10M or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nxt;
    end
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          w_nxt = w_valid ? S_SHIFT : S_REJECT;
        end
      end
      S_SHIFT: begin
        if (r_ph && r_bits == 6'd1) begin
          w_nxt = S_CSHOLD;
        end
      end
      S_CSHOLD: w_nxt = S_IOUPD;
      S_IOUPD: begin
        if (r_cnt == LP_IOU_LAST) begin
          w_nxt = S_IDLE;
        end
      end
      S_REJECT: begin
        if (r_cnt == 4'd1) begin
          w_nxt = S_IDLE;
        end
      end
      default: w_nxt = S_IDLE;
    endcase
    if (MRSET) begin
      w_nxt = S_IDLE;
    end
  end

  // Pin outputs are registered from the next state so they never glitch.
  always_ff @(posedge CLOCK_10M or negedge RESET_N) begin
    if (!RESET_N) begin
      r_tr    <= 1'b1;
      r_sh    <= '0;
      r_ph    <= 1'b0;
      r_bits  <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_csn   <= 1'b1;
      r_ioupd <= 1'b0;
      r_mrst  <= 1'b1;
    end else begin
      r_tr    <= TR;
      r_mrst  <= MRSET;
      r_busy  <= (w_nxt != S_IDLE);
      r_csn   <= !(w_nxt == S_SHIFT || w_nxt == S_CSHOLD);
      r_ioupd <= (w_nxt == S_IOUPD);
      r_cnt   <= (w_nxt != r_state) ? 4'd0 : r_cnt + 4'd1;
      if (w_nxt != S_SHIFT) begin
        r_sh   <= '0;
        r_ph   <= 1'b0;
        r_bits <= '0;
      end else if (r_state != S_SHIFT) begin
        r_sh   <= frame_word(ADDR, DATA);
        r_ph   <= 1'b0;
        r_bits <= frame_bits(ADDR);
      end else begin
        r_ph <= ~r_ph;
        if (r_ph) begin
          r_sh   <= {r_sh[38:0], 1'b0};
          r_bits <= r_bits - 6'd1;
        end
      end
    end
  end

  assign BUSY         = r_busy;
  assign SCLK         = r_ph;
  assign SDIO         = r_sh[39];
  assign CS_N         = r_csn;
  assign IO_UPDATE    = r_ioupd;
  assign MASTER_RESET = r_mrst;

endmodule

// File: tb/tb_ad9911_spi_writer.sv
// Directed bench for ad9911_spi_writer with a frame scoreboard
// fed at stimulus time and drained when CS_N rises.
module tb_ad9911_spi_writer;

  logic        CLOCK_10M;
  logic        RESET_N;
  logic        TR;
  logic [7:0]  ADDR;
  logic [31:0] DATA;
  logic        MRSET;
  logic        BUSY;
  logic        SCLK;
  logic        SDIO;
  logic        CS_N;
  logic        IO_UPDATE;
  logic        MASTER_RESET;

  ad9911_spi_writer #(.IOUPD_CYCLES(4)) dut (
    .CLOCK_10M    (CLOCK_10M),
    .RESET_N      (RESET_N),
    .TR           (TR),
    .ADDR         (ADDR),
    .DATA         (DATA),
    .MRSET        (MRSET),
    .BUSY         (BUSY),
    .SCLK         (SCLK),
    .SDIO         (SDIO),
    .CS_N         (CS_N),
    .IO_UPDATE    (IO_UPDATE),
    .MASTER_RESET (MASTER_RESET)
  );

  typedef struct {
    int          nbits;
    logic [39:0] bits;
    bit          abort;
  } exp_t;

  exp_t sb[$];

  int n_chk = 0;
  int n_err = 0;

  int sclk_total  = 0;
  int iou_pulses  = 0;
  int last_iou    = 0;
  int csn_falls   = 0;
  int frames      = 0;
  int busy_done   = 0;
  int last_busy   = 0;
  int busy_cycles = 0;

  initial begin
    CLOCK_10M = 0;
    forever #50 CLOCK_10M = ~CLOCK_10M;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int tb_bytes(input logic [7:0] a);
    if (a == 8'h00) return 1;
    if (a == 8'h02 || a == 8'h05 || a == 8'h07) return 2;
    if (a == 8'h01 || a == 8'h03 || a == 8'h06) return 3;
    return 4;
  endfunction

  function automatic logic [39:0] tb_frame(input logic [7:0] a,
                                           input logic [31:0] d);
    int n;
    logic [39:0] m;
    n = tb_bytes(a);
    m = (40'd1 << (8 * n)) - 40'd1;
    return (40'(a[4:0]) << (8 * n)) | (40'(d) & m);
  endfunction

  logic        p_sclk = 0, p_csn = 1, p_busy = 0, p_iou = 0, p_sdio = 0;
  logic [39:0] cap = 0;
  int          ncap = 0;
  int          bcnt = 0;
  int          icnt = 0;

  always @(negedge CLOCK_10M) begin
    exp_t e;
    if (!RESET_N) begin
      cap  = 0;
      ncap = 0;
    end else begin
      if (SCLK && !p_sclk) begin
        cap = {cap[38:0], SDIO};
        ncap++;
        sclk_total++;
      end
      if (SCLK && p_sclk) chk("sdio_hold", 64'(SDIO), 64'(p_sdio));
      if (IO_UPDATE) chk("iou_csn_high", 64'(CS_N), 64'd1);
      if (!CS_N && p_csn) csn_falls++;
      if (CS_N && !p_csn) begin
        frames++;
        if (sb.size() == 0) begin
          chk("unexpected_frame", 64'(ncap), 64'd0);
        end else begin
          e = sb.pop_front();
          if (e.abort) begin
            chk("abort_short", 64'(ncap < e.nbits), 64'd1);
          end else begin
            chk("frame_bits", 64'(ncap), 64'(e.nbits));
            chk("frame_data", 64'(cap), 64'(e.bits));
          end
        end
        cap  = 0;
        ncap = 0;
      end
    end
    if (BUSY) begin
      bcnt++;
      busy_cycles++;
    end else if (p_busy) begin
      last_busy = bcnt;
      busy_done++;
      bcnt = 0;
    end
    if (IO_UPDATE) icnt++;
    else if (p_iou) begin
      last_iou = icnt;
      iou_pulses++;
      icnt = 0;
    end
    p_sclk = SCLK;
    p_csn  = CS_N;
    p_busy = BUSY;
    p_iou  = IO_UPDATE;
    p_sdio = SDIO;
  end

  task automatic push(input logic [7:0] a, input logic [31:0] d,
                      input bit ab);
    exp_t e;
    e.nbits = 8 * (tb_bytes(a) + 1);
    e.bits  = tb_frame(a, d);
    e.abort = ab;
    sb.push_back(e);
  endtask

  task automatic pulse_tr(input logic [7:0] a, input logic [31:0] d);
    @(negedge CLOCK_10M);
    ADDR = a;
    DATA = d;
    TR   = 1;
    @(negedge CLOCK_10M);
    TR   = 0;
  endtask

  task automatic wait_done(input int b0);
    for (int i = 0; i < 400; i++) begin
      if (busy_done != b0) break;
      @(negedge CLOCK_10M);
    end
    @(negedge CLOCK_10M);
    chk("done_in_time", 64'(busy_done != b0), 64'd1);
  endtask

  task automatic write_chk(input logic [7:0] a, input logic [31:0] d);
    int s0, i0, c0, b0, n;
    bit ok;
    ok = (a <= 8'h18);
    n  = tb_bytes(a);
    s0 = sclk_total;
    i0 = iou_pulses;
    c0 = csn_falls;
    b0 = busy_done;
    if (ok) push(a, d, 0);
    pulse_tr(a, d);
    chk("acc_busy", 64'(BUSY), 64'd1);
    chk("acc_csn", 64'(CS_N), ok ? 64'd0 : 64'd1);
    chk("acc_sclk", 64'(SCLK), 64'd0);
    chk("acc_sdio", 64'(SDIO), 64'd0);
    wait_done(b0);
    if (ok) begin
      chk("busy_len", 64'(last_busy), 64'(16 * (n + 1) + 1 + 4));
      chk("sclk_edges", 64'(sclk_total - s0), 64'(8 * (n + 1)));
      chk("iou_pulses", 64'(iou_pulses - i0), 64'd1);
      chk("iou_len", 64'(last_iou), 64'd4);
    end else begin
      chk("rej_busy_len", 64'(last_busy), 64'd2);
      chk("rej_sclk", 64'(sclk_total - s0), 64'd0);
      chk("rej_iou", 64'(iou_pulses - i0), 64'd0);
      chk("rej_csn", 64'(csn_falls - c0), 64'd0);
    end
  endtask

  initial begin
    int f0, b0, i0, bc0;
    TR      = 0;
    ADDR    = 0;
    DATA    = 0;
    MRSET   = 0;
    RESET_N = 1;
    #20 RESET_N = 0;
    #1;
    chk("rst_busy", 64'(BUSY), 64'd0);
    chk("rst_sclk", 64'(SCLK), 64'd0);
    chk("rst_sdio", 64'(SDIO), 64'd0);
    chk("rst_csn", 64'(CS_N), 64'd1);
    chk("rst_iou", 64'(IO_UPDATE), 64'd0);
    chk("rst_mrst", 64'(MASTER_RESET), 64'd1);
    #209 RESET_N = 1;
    repeat (3) @(negedge CLOCK_10M);
    chk("mrst_follow", 64'(MASTER_RESET), 64'd0);

    write_chk(8'h04, 32'h1614_0C31);
    write_chk(8'h00, 32'h0000_0020);
    write_chk(8'h1F, 32'hDEAD_BEEF);
    write_chk(8'h07, 32'hA5C3_9E71);
    write_chk(8'h03, 32'h00F0_0F5A);
    write_chk(8'h18, 32'h8000_0001);
    write_chk(8'h19, 32'h1234_5678);
    write_chk(8'h06, $urandom);

    // TR held high: exactly one frame, then a fresh edge gives another
    f0 = frames;
    push(8'h00, 32'h0000_0055, 0);
    @(negedge CLOCK_10M);
    ADDR = 8'h00;
    DATA = 32'h0000_0055;
    TR   = 1;
    repeat (200) @(negedge CLOCK_10M);
    chk("held_one_frame", 64'(frames - f0), 64'd1);
    TR = 0;
    write_chk(8'h02, 32'h0000_3C96);
    chk("held_second", 64'(frames - f0), 64'd2);

    // master reset at bit 10 of a CTW0 write
    i0 = iou_pulses;
    push(8'h04, 32'hCAFE_F00D, 1);
    pulse_tr(8'h04, 32'hCAFE_F00D);
    repeat (20) @(negedge CLOCK_10M);
    MRSET = 1;
    @(negedge CLOCK_10M);
    MRSET = 0;
    chk("mr_busy", 64'(BUSY), 64'd0);
    chk("mr_csn", 64'(CS_N), 64'd1);
    chk("mr_sclk", 64'(SCLK), 64'd0);
    chk("mr_sdio", 64'(SDIO), 64'd0);
    chk("mr_pin", 64'(MASTER_RESET), 64'd1);
    repeat (20) @(negedge CLOCK_10M);
    chk("mr_no_iou", 64'(iou_pulses - i0), 64'd0);
    chk("mr_idle", 64'(BUSY), 64'd0);

    // async reset during IO_UPDATE, TR high at release
    push(8'h00, 32'h0000_0020, 0);
    pulse_tr(8'h00, 32'h0000_0020);
    for (int i = 0; i < 100; i++) begin
      if (IO_UPDATE) break;
      @(negedge CLOCK_10M);
    end
    chk("iou_reached", 64'(IO_UPDATE), 64'd1);
    TR = 1;
    #10 RESET_N = 0;
    #1;
    chk("ar_iou", 64'(IO_UPDATE), 64'd0);
    chk("ar_busy", 64'(BUSY), 64'd0);
    chk("ar_csn", 64'(CS_N), 64'd1);
    repeat (3) @(negedge CLOCK_10M);
    f0  = frames;
    bc0 = busy_cycles;
    #30 RESET_N = 1;
    repeat (30) @(negedge CLOCK_10M);
    chk("ar_no_frame", 64'(frames - f0), 64'd0);
    chk("ar_no_busy", 64'(busy_cycles - bc0), 64'd0);
    TR = 0;
    write_chk(8'h05, 32'h0000_ABCD);

    b0 = busy_done;
    repeat (5) @(negedge CLOCK_10M);
    chk("final_quiet", 64'(busy_done - b0), 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ad9911_spi_writer.md
AD9911_SPI_WRITER -- requirements
Module: ad9911_spi_writer

Interface
REQ-001 Parameter IOUPD_CYCLES, default 4: IO_UPDATE pulse width in clock cycles (range 1..15).
REQ-002 CLOCK_10M  in  1  sole clock, 10 MHz, all logic on rising edge.
REQ-003 RESET_N  in  1  reset, asynchronous, active-low.
REQ-004 TR  in  1  write request; a rising edge starts one register write.
REQ-005 ADDR  in  8  AD9911 register address.
REQ-006 DATA  in  32  register value, LSB-aligned.
REQ-007 MRSET  in  1  master-reset request from the updater.
REQ-008 BUSY  out  1  high from acceptance until the write and IO_UPDATE complete.
REQ-009 SCLK  out  1  serial clock to AD9911, idle low.
REQ-010 SDIO  out  1  serial data to AD9911, MSB first.
REQ-011 CS_N  out  1  chip select, active-low.
REQ-012 IO_UPDATE  out  1  register-transfer strobe to AD9911.
REQ-013 MASTER_RESET  out  1  registered copy of MRSET driven to the AD9911 pin.

Function
REQ-014 TR shall be registered; acceptance occurs at the edge where TR=1, previous TR=0, state IDLE, MRSET=0; ADDR/DATA are latched at that edge.
REQ-015 TR edges arriving outside IDLE shall be ignored; TR held high shall not retrigger.
REQ-016 Payload byte count N by address: 0x00 -> 1; 0x02, 0x05, 0x07 -> 2; 0x01, 0x03, 0x06 -> 3; 0x04, 0x08..0x18 -> 4.
REQ-017 Frame = instruction byte {1'b0, 2'b00, ADDR[4:0]} followed by DATA[8N-1:0], MSB first, 8(N+1) bits total.
REQ-018 States: IDLE, SHIFT, CSHOLD, IOUPD, REJECT.
REQ-019 IDLE -> SHIFT on valid-address acceptance; BUSY=1, CS_N=0, SCLK=0 and SDIO=first bit in the first cycle after acceptance.
REQ-020 SHIFT: each bit occupies 2 cycles: SCLK=0 with SDIO valid, then SCLK=1 with SDIO held; SDIO changes only while SCLK is low; 16(N+1) cycles total.
REQ-021 SHIFT -> CSHOLD after the last SCLK-high cycle; CSHOLD lasts 1 cycle with SCLK=0, CS_N=0.
REQ-022 CSHOLD -> IOUPD; IOUPD lasts IOUPD_CYCLES cycles with CS_N=1, IO_UPDATE=1.
REQ-023 IOUPD -> IDLE; BUSY=0 in the first IDLE cycle; BUSY high time = 16(N+1)+1+IOUPD_CYCLES cycles.
REQ-024 Address > 0x18: IDLE -> REJECT; BUSY=1 for exactly 2 cycles; no CS_N, SCLK or IO_UPDATE activity; then IDLE.
REQ-025 MRSET=1 at any state shall force IDLE on the next edge: BUSY=0, CS_N=1, SCLK=0, SDIO=0, IO_UPDATE=0; an in-flight frame is dropped and not resumed.
REQ-026 Bit counter width shall cover 40 bits; no wrap-around is permitted within a frame.

Reset
REQ-027 RESET_N low shall asynchronously set BUSY=0, SCLK=0, SDIO=0, CS_N=1, IO_UPDATE=0, MASTER_RESET=1, state=IDLE, and the registered TR to 1 so that a TR already high at release is not accepted.
REQ-028 Reset mid-frame shall abort without completing the frame or issuing IO_UPDATE.

Structure
REQ-029 Shared package ad9911_pkg shall hold register address constants (CSR..CTW1, max 0x18), the address-to-byte-count function and the state encoding.
REQ-030 No sub-module; shift register, bit counter and FSM shall reside in ad9911_spi_writer.

Verification
REQ-031 Write ADDR=0x04, DATA=0x1614_0C31 -> 40 SCLK rising edges, SDIO stream 0x04 then 0x16140C31; BUSY high 85 cycles; one 4-cycle IO_UPDATE after CS_N rises.
REQ-032 Write ADDR=0x00, DATA=0x0000_0020 -> 16 SCLK edges, SDIO 0x00 then 0x20; BUSY high 37 cycles.
REQ-033 Write ADDR=0x1F -> BUSY high 2 cycles; CS_N stays 1; no SCLK edges; no IO_UPDATE pulse.
REQ-034 TR held high for 200 cycles -> exactly one frame; a second rising edge after BUSY falls -> a second frame.
REQ-035 MRSET=1 at bit 10 of a CTW0 write -> next cycle BUSY=0, CS_N=1, MASTER_RESET=1; no IO_UPDATE pulse.
REQ-036 RESET_N low during IOUPD -> IO_UPDATE=0 and BUSY=0 immediately (asynchronously); TR high at reset release causes no frame.
